vga_scanout: RTL

- Downstream consumer of vga_buffer.
- Generates 640x480@60 VGA timing from the system clock. Drives x_coord/y_coord/invalidate into vga_buffer and takes its 8-bit rgb back.
- Scales the 256x192 framebuffer 2x to 512x384, centred with a border, and drives the DAC pins and sync outputs.

---
 rtl/vga_scanout_pkg.sv | 50 +++++
 rtl/vga_sync_counter.sv | 89 ++++++++
 rtl/vga_scanout.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_pkg.sv
// Shared constants, types and helpers for the vga_scanout slice: framebuffer size,
// 640x480@60 timing defaults and the RRRGGGBB colour split.
package vga_scanout_pkg;

  localparam int SCREEN_WIDTH  = 256;
  localparam int SCREEN_HEIGHT = 192;

  localparam int CLK_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int X_OFFSET_DEF = 64;
  localparam int Y_OFFSET_DEF = 48;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 10;
  localparam int DIV_W = 8;

  typedef struct packed {
    logic h_span;
    logic h_left;
    logic v_pic;
    logic v_prime;
    logic active;
    logic hsync;
    logic vsync;
  } scan_flags_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic rgb332_t split_rgb(input logic [7:0] c);
    rgb332_t o;
    o.r = c[7:5];
    o.g = c[4:2];
    o.b = c[1:0];
    return o;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel divider, horizontal/vertical counters and the raw sync/region flags
// decoded from them (undelayed; the scanout pipeline aligns them).
module vga_sync_counter
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int X_OFFSET = X_OFFSET_DEF,
  parameter int Y_OFFSET = Y_OFFSET_DEF,
  parameter int PIC_ROWS = SCREEN_HEIGHT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_wrap,
  output scan_flags_t      flags
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] X_LO     = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] X_HI     = CNT_W'(X_OFFSET + 2 * SCREEN_WIDTH);
  localparam logic [CNT_W-1:0] Y_LO     = CNT_W'(Y_OFFSET);
  localparam logic [CNT_W-1:0] Y_HI     = CNT_W'(Y_OFFSET + 2 * PIC_ROWS);
  localparam logic [CNT_W-1:0] Y_PRIME  = CNT_W'(Y_OFFSET - 1);

  logic [DIV_W-1:0] div_cnt;

  assign pix_en     = (div_cnt == DIV_LAST);
  assign frame_wrap = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Clock divider producing one pix_en strobe every CLK_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Raster position; v advances on the h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        h_cnt <= h_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign flags.h_left  = (h_cnt < X_LO);
  assign flags.h_span  = (h_cnt >= X_LO) && (h_cnt < X_HI);
  assign flags.v_pic   = (v_cnt >= Y_LO) && (v_cnt < Y_HI);
  assign flags.v_prime = (v_cnt == Y_PRIME);
  assign flags.active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign flags.hsync   = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
  assign flags.vsync   = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: 2x-scaled, centred framebuffer fetch and DAC/sync pins.
// Optional macro VGA_BORDER_COLOR_EN adds a border_color input for the border area.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int X_OFFSET = X_OFFSET_DEF,
  parameter int Y_OFFSET = Y_OFFSET_DEF,
  parameter int PIC_ROWS = SCREEN_HEIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] x_coord,
  output logic [7:0] y_coord,
  output logic       invalidate,
  input  logic [7:0] rgb,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_BORDER_COLOR_EN
  ,
  input  logic [7:0] border_color
`endif
);

  localparam logic [CNT_W-1:0] X_LO   = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(Y_OFFSET);
  localparam logic [7:0]       Y_IDLE = 8'(PIC_ROWS - 1);

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             frame_wrap;
  scan_flags_t      flags;

  logic [8:0] v_rel;
  logic [7:0] x_next;
  logic [7:0] y_next;
  logic       inv_next;
  logic       pic_d;
  logic       act_d;
  logic       hsync_d;
  logic       vsync_d;
  logic [7:0] border;
  rgb332_t    pix_next;

  vga_sync_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET),
    .PIC_ROWS (PIC_ROWS)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_wrap (frame_wrap),
    .flags      (flags)
  );

`ifdef VGA_BORDER_COLOR_EN
  assign border = border_color;
`else
  assign border = 8'd0;
`endif

  assign v_rel = 9'(v_cnt - Y_LO);

  // Next fetch coordinate; each framebuffer row is released only after its second showing
  always_comb begin
    x_next   = 8'd0;
    y_next   = Y_IDLE;
    inv_next = 1'b0;
    if (flags.h_span) begin
      x_next = 8'((h_cnt - X_LO) >> 1);
    end else if (flags.h_left) begin
      x_next = 8'd0;
    end else begin
      x_next = 8'd255;
    end
    if (flags.v_pic) begin
      y_next = v_rel[8:1];
    end else begin
      y_next = Y_IDLE;
    end
    if (flags.h_span && ((flags.v_pic && v_rel[0]) || flags.v_prime)) begin
      inv_next = 1'b1;
    end else begin
      inv_next = 1'b0;
    end
  end

  // Coordinate stage, with region and sync flags delayed to match the pixel stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_coord    <= 8'd0;
      y_coord    <= Y_IDLE;
      invalidate <= 1'b0;
      pic_d      <= 1'b0;
      act_d      <= 1'b0;
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
    end else if (pix_en) begin
      x_coord    <= x_next;
      y_coord    <= y_next;
      invalidate <= inv_next;
      pic_d      <= flags.h_span && flags.v_pic;
      act_d      <= flags.active;
      hsync_d    <= flags.hsync;
      vsync_d    <= flags.vsync;
    end
  end

  // Pin colour: picture byte, border, or black in blanking
  always_comb begin
    pix_next = '0;
    if (pic_d) begin
      pix_next = split_rgb(rgb);
    end else if (act_d) begin
      pix_next = split_rgb(border);
    end else begin
      pix_next = '0;
    end
  end

  // Pixel stage driving the DAC and sync pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= 3'd0;
      vga_g <= 3'd0;
      vga_b <= 2'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      vga_r <= pix_next.r;
      vga_g <= pix_next.g;
      vga_b <= pix_next.b;
      hsync <= hsync_d;
      vsync <= vsync_d;
    end
  end

  // Single-clock frame marker as the raster returns to (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
    end
  end

endmodule
